// File: rtl/ycconf_loader.sv
// ycconf_loader: serialises 3-bit cell codes into a chain of ycconfig cells.
// Each code goes out MSB first as three confclk pulses. The bit pushed out of
// the chain tail on each pulse is collected, so the code that was in the tail
// cell comes back on rb_code.
//
// Handshake: a code transfers on a clk edge where cfg_valid && cfg_ready.
// cfg_ready is high only in IDLE. The producer must hold cfg_code stable while
// cfg_valid is high and cfg_ready is low.
module ycconf_loader #(
  parameter int HALF   = 2,
  parameter int NCELLS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  input  logic [2:0] cfg_code,
  output logic       cfg_ready,
  output logic       confclk,
  output logic       cbitin,
  input  logic       cbitout,
  output logic       rb_valid,
  output logic [2:0] rb_code,
  output logic       done,
  output logic [7:0] cell_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HIGH  = 2'd2
  } state_t;

  localparam logic [3:0] PH_LAST  = 4'(HALF - 1);
  localparam logic [7:0] CNT_LAST = 8'(NCELLS - 1);

  state_t     r_state;
  logic [2:0] r_sr;
  logic [1:0] r_bitcnt;
  logic [3:0] r_phase;
  logic [7:0] r_cellcnt;
  logic       r_confclk;
  logic [2:0] r_rb;
  logic [2:0] r_rb_code;
  logic       r_rb_valid;
  logic       r_done;

  // Readback value completed on this edge: earlier samples plus the tail bit.
  logic [2:0] w_rb_next;
  assign w_rb_next = {r_rb[1:0], cbitout};

  // Sequencer: accepts a code, then alternates SETUP/HIGH for three bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sr       <= 3'b000;
      r_bitcnt   <= 2'd0;
      r_phase    <= 4'd0;
      r_cellcnt  <= 8'd0;
      r_confclk  <= 1'b0;
      r_rb       <= 3'b000;
      r_rb_code  <= 3'b000;
      r_rb_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_valid) begin
            r_sr     <= cfg_code;
            r_bitcnt <= 2'd0;
            r_phase  <= 4'd0;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_phase == PH_LAST) begin
            // confclk rises here; the chain has not shifted yet, so cbitout
            // is the bit about to be displaced from the tail.
            r_phase   <= 4'd0;
            r_confclk <= 1'b1;
            r_state   <= S_HIGH;
            r_rb      <= w_rb_next;
            if (r_bitcnt == 2'd2) begin
              r_rb_code  <= w_rb_next;
              r_rb_valid <= 1'b1;
            end
          end else begin
            r_phase <= r_phase + 4'd1;
          end
        end
        S_HIGH: begin
          if (r_phase == PH_LAST) begin
            r_phase   <= 4'd0;
            r_confclk <= 1'b0;
            if (r_bitcnt != 2'd2) begin
              // Shift the next bit up to the MSB, which drives cbitin.
              r_sr     <= {r_sr[1:0], 1'b0};
              r_bitcnt <= r_bitcnt + 2'd1;
              r_state  <= S_SETUP;
            end else begin
              // Last bit sent: r_sr is left alone so cbitin holds in IDLE.
              r_state <= S_IDLE;
              if (r_cellcnt == CNT_LAST) begin
                r_cellcnt <= 8'd0;
                r_done    <= 1'b1;
              end else begin
                r_cellcnt <= r_cellcnt + 8'd1;
              end
            end
          end else begin
            r_phase <= r_phase + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cfg_ready = (r_state == S_IDLE);
  assign confclk   = r_confclk;
  assign cbitin    = r_sr[2];
  assign rb_valid  = r_rb_valid;
  assign rb_code   = r_rb_code;
  assign done      = r_done;
  assign cell_cnt  = r_cellcnt;

endmodule

// File: doc/ycconf_loader.md
YCCONF_LOADER -- requirements
Module: ycconf_loader

Interface
REQ-001 The module SHALL have a parameter HALF, default 2, giving the number of clk cycles in each confclk half-period (legal range 1..15).
REQ-002 The module SHALL have a parameter NCELLS, default 4, giving the number of ycconfig cells in the chain (legal range 1..255).
REQ-003 The ports SHALL be, one per line, as follows.
- clk  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- cfg_valid  input  1  cfg_code is offered.
- cfg_code  input  3  cell code: 000 space, 001 +, 010 -, 011 |, 100 1, 101 0, 110 Y, 111 N.
- cfg_ready  output  1  loader accepts a code this cycle.
- confclk  output  1  configuration clock to the chain.
- cbitin  output  1  serial data to the chain head.
- cbitout  input  1  serial data from the chain tail.
- rb_valid  output  1  one-cycle pulse: rb_code is valid.
- rb_code  output  3  code displaced out of the chain tail.
- done  output  1  one-cycle pulse when NCELLS codes have been shifted.
- cell_cnt  output  8  number of codes shifted in the current frame.

Function
REQ-004 The state machine SHALL have exactly three states, IDLE, SETUP and HIGH, plus a 2-bit bit counter, a 4-bit phase counter and an 8-bit cell counter.
REQ-005 cfg_ready SHALL be 1 exactly when the state is IDLE.
REQ-006 A transfer SHALL occur on a clk edge with cfg_valid=1 and cfg_ready=1.
- Load cfg_code into a 3-bit shift register.
- Clear the bit counter.
- Go to SETUP.
REQ-007 cfg_code SHALL be ignored when cfg_ready=0, and no data SHALL be lost or duplicated in that case.
REQ-008 SETUP SHALL behave as follows.
- Drive confclk=0 and cbitin equal to the shift-register MSB.
- Last exactly HALF clk cycles, then go to HIGH.
REQ-009 HIGH SHALL behave as follows.
- Drive confclk=1 for exactly HALF clk cycles.
- Hold cbitin unchanged for the whole state.
REQ-010 When HIGH ends with the bit counter below 2, the loader SHALL shift the register left by one, increment the bit counter and return to SETUP.
REQ-011 When HIGH ends with the bit counter equal to 2, the loader SHALL increment cell_cnt and return to IDLE.
REQ-012 Each code SHALL be sent MSB first as exactly 3 confclk pulses, and SHALL occupy 6*HALF clk cycles from acceptance to the return to IDLE.
REQ-013 In IDLE, confclk SHALL be 0 and cbitin SHALL hold its last value.
REQ-014 confclk and cbitin SHALL be driven directly from flops, with no combinational path from any input.
REQ-015 Readback: on the clk edge where the state enters HIGH, the loader SHALL shift cbitout into a 3-bit readback register, MSB first.
REQ-016 rb_valid SHALL pulse for one cycle, together with the update of rb_code, on the third readback sample of each code.
REQ-017 When cell_cnt would reach NCELLS, the loader SHALL instead clear cell_cnt to 0 and pulse done for one cycle, coinciding with the return to IDLE.
REQ-018 Boundary behaviour SHALL be as follows.
- A new code accepted in the first IDLE cycle gives back-to-back codes with a single IDLE cycle between them.
- cfg_valid held high continuously loads one code per 6*HALF+1 cycles.
- NCELLS=1 pulses done after every code.

Reset
REQ-019 While rst_n=0, asynchronously and irrespective of clk, the outputs SHALL be:
- state IDLE;
- confclk=0, cbitin=0;
- cfg_ready=1 after deassertion;
- rb_valid=0, rb_code=000;
- done=0, cell_cnt=0;
- all counters 0.
REQ-020 Reset asserted mid-code SHALL drop confclk to 0 immediately, and the partial code SHALL be discarded and not counted.
REQ-021 The first transfer after rst_n rises SHALL be accepted on the first clk edge with cfg_valid=1.

Verification
REQ-022 Single code: HALF=2, send 110 (Y) -> confclk shows 3 pulses, each 2 cycles high; cbitin is 1,1,0 at the rising edges; cfg_ready is low for 12 cycles; cell_cnt=1.
REQ-023 Chain check: connect 2 ycconfig cells in cascade, NCELLS=2, send 001 (+) then 111 (N) -> the head cell decodes N, the tail cell decodes +, done pulses once and cell_cnt returns to 0.
REQ-024 Readback: chain of 2 preloaded with +,N; send 000,000 -> rb_code returns codes that reproduce the preloaded chain contents, each with one rb_valid pulse.
REQ-025 Back-pressure: cfg_valid held high with codes 000..111 -> all 8 codes are shifted in order, exactly one per 13 cycles at HALF=2, with none skipped.
REQ-026 Reset mid-operation: assert rst_n=0 during HIGH of bit 2 -> confclk=0 in the same cycle, cell_cnt=0; the next code loads cleanly.
REQ-027 Parameter sweep: HALF=1 and NCELLS=1 with code 101 -> confclk alternates every cycle, and done pulses after 6 cycles.
